fifo_reader: RTL and testbench

Read-side controller for the transaction-layer FIFO: it drives pop, captures the FIFO's 1-cycle-latency read data, and presents it downstream with a valid/ready handshake. It loads and drives the almost-full/almost-empty thresholds (umbral_superior/umbral_inferior) into the FIFO and runs the block's RESET/INIT/IDLE/ACTIVE/ERROR state machine. It sits between the FIFO output and the next transaction-layer stage.

---
 rtl/fifo_reader_pkg.sv | 19 +
 rtl/fifo_reader_if.sv | 27 ++
 rtl/fifo_reader_skid.sv | 53 +++++
 rtl/fifo_reader.sv | 101 ++++++++++
 tb/tb_fifo_reader.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the transaction-layer FIFO blocks: widths,
// threshold reset defaults and the controller state encoding.
package fifo_reader_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned UMB_W  = 3;

  localparam logic [UMB_W-1:0] UMB_SUP_RST = 3'b110;
  localparam logic [UMB_W-1:0] UMB_INF_RST = 3'b001;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready channel of the FIFO reader.
interface fifo_reader_if
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W = fifo_reader_pkg::DATA_W
);

  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_in;

  modport master (
    input  fifo_empty, almost_full, almost_empty, fifo_data, ready_in,
    output pop, data_out, valid_out
  );

  modport slave (
    output fifo_empty, almost_full, almost_empty, fifo_data, ready_in,
    input  pop, data_out, valid_out
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order skid buffer absorbing the FIFO's one-cycle read latency.
module fifo_reader_skid #(
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic              xfer;

  assign valid_out = (occ != 2'd0);
  assign data_out  = head;
  assign xfer      = valid_out & ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      case ({capture, xfer})
        2'b10: begin
          if (occ == 2'd0) head <= cap_data;
          else             tail <= cap_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        // Capture and drain in the same cycle: head advances, occupancy is unchanged.
        2'b11: begin
          if (occ == 2'd1) begin
            head <= cap_data;
          end else begin
            head <= tail;
            tail <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side controller: pop generation, threshold loading, state machine
// and delivered-word counter; read data is staged through a skid buffer.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned      DATA_W      = fifo_reader_pkg::DATA_W,
  parameter int unsigned      UMB_W       = fifo_reader_pkg::UMB_W,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [UMB_W-1:0] UMB_SUP_RST = fifo_reader_pkg::UMB_SUP_RST,
  parameter logic [UMB_W-1:0] UMB_INF_RST = fifo_reader_pkg::UMB_INF_RST
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  input  logic [UMB_W-1:0] umbral_superior_in,
  input  logic [UMB_W-1:0] umbral_inferior_in,
  output logic [UMB_W-1:0] umbral_superior,
  output logic [UMB_W-1:0] umbral_inferior,
  output logic [2:0]       state_out,
  output logic             idle_out,
  output logic             error_out,
  output logic [CNT_W-1:0] words_out,
  fifo_reader_if.master    bus
);

  state_t     state;
  state_t     state_nxt;
  logic       inflight;
  logic       xfer;
  logic       pop_int;
  logic [1:0] occ;
  logic [1:0] pend;
  logic       status_unused;

  assign xfer          = bus.valid_out & bus.ready_in;
  assign pend          = occ + {1'b0, inflight};
  assign bus.pop       = pop_int;
  assign status_unused = bus.almost_full ^ bus.almost_empty;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= ST_RESET;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RESET: state_nxt = ST_INIT;
      ST_INIT: begin
        if (!init) state_nxt = (umbral_inferior >= umbral_superior) ? ST_ERROR : ST_IDLE;
      end
      ST_IDLE: begin
        if (init)                 state_nxt = ST_INIT;
        else if (!bus.fifo_empty) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (bus.fifo_empty && !inflight && occ == 2'd0) state_nxt = ST_IDLE;
      end
      ST_ERROR: state_nxt = ST_ERROR;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // Words owed to the buffer never exceed two unless one leaves this cycle.
  always_comb begin
    pop_int = 1'b0;
    if (state == ST_ACTIVE && !bus.fifo_empty)
      pop_int = (pend < 2'd2) || (pend == 2'd2 && xfer);
    idle_out  = (state == ST_IDLE);
    error_out = (state == ST_ERROR);
    state_out = state;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      inflight        <= 1'b0;
      words_out       <= '0;
      umbral_superior <= UMB_SUP_RST;
      umbral_inferior <= UMB_INF_RST;
    end else begin
      inflight <= pop_int;
      if (xfer) words_out <= words_out + CNT_W'(1);
      if (state == ST_INIT && init) begin
        umbral_superior <= umbral_superior_in;
        umbral_inferior <= umbral_inferior_in;
      end
    end
  end

  fifo_reader_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst_n     (reset_L),
    .capture   (inflight),
    .cap_data  (bus.fifo_data),
    .ready_in  (bus.ready_in),
    .valid_out (bus.valid_out),
    .data_out  (bus.data_out),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: threshold-load vector table plus directed sequences
// for streaming, backpressure, error lock, async reset and counter wrap.
module tb_fifo_reader;
  import fifo_reader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_L, init;
  logic [2:0] sup_in, inf_in;
  logic [2:0] umb_sup, umb_inf, st, umb_sup2, umb_inf2, st2;
  logic       idle, err, idle2, err2;
  logic [15:0] words;
  logic [3:0]  words2;

  fifo_reader_if #(.DATA_W(10)) bus ();
  fifo_reader_if #(.DATA_W(10)) bus2 ();

  fifo_reader #(.DATA_W(10), .UMB_W(3), .CNT_W(16),
                .UMB_SUP_RST(3'b110), .UMB_INF_RST(3'b001)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_superior_in(sup_in), .umbral_inferior_in(inf_in),
    .umbral_superior(umb_sup), .umbral_inferior(umb_inf),
    .state_out(st), .idle_out(idle), .error_out(err), .words_out(words),
    .bus(bus)
  );

  fifo_reader #(.DATA_W(10), .UMB_W(3), .CNT_W(4),
                .UMB_SUP_RST(3'b110), .UMB_INF_RST(3'b001)) dut_wrap (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_superior_in(sup_in), .umbral_inferior_in(inf_in),
    .umbral_superior(umb_sup2), .umbral_inferior(umb_inf2),
    .state_out(st2), .idle_out(idle2), .error_out(err2), .words_out(words2),
    .bus(bus2)
  );

  int n_pass = 0;
  int n_tot = 0;
  int underflow = 0;
  logic [9:0] fq[$];
  logic [9:0] rx[$];
  logic pop_s = 1'b0;

  // Downstream monitor and pop sampler, late in the cycle after stimulus settles.
  always @(negedge clk) begin
    #3;
    pop_s = bus.pop;
    if (bus.valid_out && bus.ready_in) rx.push_back(bus.data_out);
  end

  // FIFO model: registered data and empty flag, one-cycle read latency.
  always @(posedge clk) begin
    #1;
    if (pop_s && reset_L) begin
      if (fq.size() == 0) underflow++;
      else bus.fifo_data = fq.pop_front();
    end
    bus.fifo_empty = (fq.size() == 0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    step();
    reset_L = 1'b0;
    init = 1'b0;
    fq.delete();
    rx.delete();
    bus.ready_in = 1'b1;
    bus2.ready_in = 1'b1;
    bus2.fifo_empty = 1'b1;
    step();
    step();
    reset_L = 1'b1;
  endtask

  task automatic load(input logic [2:0] s, input logic [2:0] i);
    init = 1'b1;
    sup_in = s;
    inf_in = i;
    step();
    step();
    step();
    init = 1'b0;
    step();
  endtask

  task automatic push10();
    for (int v = 1; v <= 10; v++) fq.push_back(10'(v));
  endtask

  task automatic check_rx(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < rx.size(); i++) if (rx[i] != 10'(i + 1)) bad++;
    chk({tag, "_count"}, rx.size(), 10);
    chk({tag, "_order"}, bad, 0);
  endtask

  typedef struct {
    logic [2:0] sup;
    logic [2:0] inf;
    logic [2:0] exp_state;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int pop_cnt, pop_first, pop_last, v_cnt, v_first, v_last, w, lat;
    int hold_bad, pop_bad, n;
    bit seen16;

    vecs[0] = '{3'd6, 3'd1, 3'd2, 1'b0};
    vecs[1] = '{3'd1, 3'd6, 3'd4, 1'b1};
    vecs[2] = '{3'd3, 3'd3, 3'd4, 1'b1};
    vecs[3] = '{3'd7, 3'd0, 3'd2, 1'b0};
    vecs[4] = '{3'd4, 3'd3, 3'd2, 1'b0};
    vecs[5] = '{3'd0, 3'd7, 3'd4, 1'b1};

    reset_L = 1'b0;
    init = 1'b0;
    sup_in = '0;
    inf_in = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data = '0;
    bus.almost_full = 1'b0;
    bus.almost_empty = 1'b0;
    bus.ready_in = 1'b1;
    bus2.fifo_empty = 1'b1;
    bus2.fifo_data = 10'h155;
    bus2.almost_full = 1'b0;
    bus2.almost_empty = 1'b0;
    bus2.ready_in = 1'b1;

    // Threshold-load table
    for (int k = 0; k < 6; k++) begin
      do_reset();
      if (k == 0) begin
        chk("rst_state", st, 0);
        chk("rst_sup", umb_sup, 6);
        chk("rst_inf", umb_inf, 1);
        chk("rst_err", err, 0);
        chk("rst_words", words, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_pop", bus.pop, 0);
        chk("rst_data", bus.data_out, 0);
      end
      init = 1'b1;
      sup_in = vecs[k].sup;
      inf_in = vecs[k].inf;
      step();
      chk($sformatf("vec%0d_init_state", k), st, 1);
      step();
      chk($sformatf("vec%0d_sup", k), umb_sup, vecs[k].sup);
      chk($sformatf("vec%0d_inf", k), umb_inf, vecs[k].inf);
      step();
      init = 1'b0;
      step();
      chk($sformatf("vec%0d_state", k), st, vecs[k].exp_state);
      chk($sformatf("vec%0d_err", k), err, vecs[k].exp_err);
      chk($sformatf("vec%0d_idle", k), idle, (vecs[k].exp_state == 3'd2) ? 1 : 0);
    end

    // Thresholds hold outside INIT; init in IDLE re-enters INIT
    do_reset();
    load(3'd6, 3'd1);
    sup_in = 3'd2;
    inf_in = 3'd5;
    step(); step(); step();
    chk("hold_sup", umb_sup, 6);
    chk("hold_inf", umb_inf, 1);
    init = 1'b1;
    step();
    chk("reinit_state", st, 1);
    step();
    init = 1'b0;
    step();
    chk("reinit_sup", umb_sup, 2);
    chk("reinit_err_state", st, 4);

    // Streaming with latency and contiguity
    do_reset();
    load(3'd6, 3'd1);
    bus.almost_full = 1'b1;
    bus.almost_empty = 1'b1;
    push10();
    w = 0;
    while (bus.fifo_empty && w < 5) begin step(); w++; end
    chk("stream_empty_fall", bus.fifo_empty, 0);
    chk("stream_still_idle", st, 2);
    pop_cnt = 0; pop_first = -1; pop_last = -1;
    v_cnt = 0; v_first = -1; v_last = -1;
    for (int c = 0; c < 30; c++) begin
      if (bus.pop) begin
        pop_cnt++;
        if (pop_first < 0) pop_first = c;
        pop_last = c;
      end
      if (bus.valid_out) begin
        v_cnt++;
        if (v_first < 0) v_first = c;
        v_last = c;
      end
      step();
    end
    chk("stream_pop_first", pop_first, 1);
    chk("stream_pop_cnt", pop_cnt, 10);
    chk("stream_pop_span", pop_last - pop_first + 1, 10);
    chk("stream_first_valid", v_first, 3);
    chk("stream_valid_cnt", v_cnt, 10);
    chk("stream_valid_span", v_last - v_first + 1, 10);
    check_rx("stream");
    chk("stream_words", words, 10);
    chk("stream_end_state", st, 2);
    bus.almost_full = 1'b0;
    bus.almost_empty = 1'b0;

    // Backpressure on word 3 for five cycles
    do_reset();
    load(3'd6, 3'd1);
    push10();
    lat = 0;
    while (!(bus.valid_out && bus.data_out == 10'd3) && lat < 40) begin step(); lat++; end
    chk("bp_reached_word3", bus.data_out, 3);
    bus.ready_in = 1'b0;
    chk("bp_words_before", words, 2);
    hold_bad = 0;
    pop_bad = 0;
    for (int h = 0; h < 5; h++) begin
      if (!(bus.valid_out && bus.data_out == 10'd3)) hold_bad++;
      if (h >= 1 && bus.pop) pop_bad++;
      step();
    end
    chk("bp_hold_data", hold_bad, 0);
    chk("bp_pop_stalled", pop_bad, 0);
    bus.ready_in = 1'b1;
    repeat (30) step();
    check_rx("bp");
    chk("bp_words", words, 10);
    chk("bp_end_state", st, 2);

    // Invalid thresholds lock into ERROR; init ignored; only reset clears
    do_reset();
    load(3'd1, 3'd6);
    chk("err_state", st, 4);
    chk("err_flag", err, 1);
    push10();
    pop_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      init = (c >= 5 && c < 10);
      sup_in = 3'd7;
      inf_in = 3'd0;
      if (bus.pop) pop_cnt++;
      step();
    end
    init = 1'b0;
    chk("err_no_pop", pop_cnt, 0);
    chk("err_sticky_state", st, 4);
    chk("err_sticky_flag", err, 1);
    chk("err_sup_kept", umb_sup, 1);
    reset_L = 1'b0;
    #1;
    chk("err_cleared", err, 0);
    chk("err_cleared_state", st, 0);

    // Asynchronous reset mid-burst
    do_reset();
    load(3'd6, 3'd1);
    push10();
    lat = 0;
    while (rx.size() < 4 && lat < 40) begin step(); lat++; end
    chk("mid_pop_active", bus.pop, 1);
    reset_L = 1'b0;
    #1;
    chk("mid_pop", bus.pop, 0);
    chk("mid_valid", bus.valid_out, 0);
    chk("mid_words", words, 0);
    chk("mid_data", bus.data_out, 0);
    chk("mid_state", st, 0);
    fq.delete();
    step();
    reset_L = 1'b1;
    #1;
    chk("mid_rel_state", st, 0);
    step();
    chk("mid_init_state", st, 1);

    // Counter wrap on the 4-bit instance
    do_reset();
    load(3'd6, 3'd1);
    bus2.fifo_empty = 1'b0;
    n = 0;
    seen16 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (n == 16 && !seen16) begin
        chk("wrap_at16", words2, 0);
        seen16 = 1'b1;
      end
      if (n == 17) break;
      if (bus2.valid_out && bus2.ready_in) n++;
    end
    bus2.ready_in = 1'b0;
    bus2.fifo_empty = 1'b1;
    chk("wrap_transfers", n, 17);
    chk("wrap_words", words2, 1);

    chk("fifo_no_underflow", underflow, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
